mem_bus_arbiter: RTL and testbench

//  Two-master arbiter for the picorv32 native memory bus. Shares one single-port synchronous RAM

---
 rtl/soc_bus_pkg.sv | 33 +++
 rtl/rr_arb2.sv | 23 ++
 rtl/mem_bus_arbiter.sv | 158 +++++++++++++++
 tb/tb_mem_bus_arbiter.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/soc_bus_pkg.sv
// Shared definitions for the picorv32 native-bus RAM arbiter: FSM encoding,
// master IDs, request payload and the RAM address-range check.
package soc_bus_pkg;

   localparam int unsigned ADDR_W = 32;
   localparam int unsigned DATA_W = 32;
   localparam int unsigned STRB_W = 4;

   localparam logic MST_CPU = 1'b0;
   localparam logic MST_LDR = 1'b1;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_WAIT   = 2'd2,
      ST_RESP   = 2'd3
   } bus_state_e;

   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] wdata;
      logic [STRB_W-1:0] wstrb;
   } bus_req_t;

   // True when every byte-address bit above the RAM word index is zero.
   function automatic logic addr_in_range(input logic [ADDR_W-1:0] addr,
                                          input int unsigned       ram_aw);
      logic [ADDR_W-1:0] upper;
      upper = addr >> (ram_aw + 2);
      return (upper == '0);
   endfunction

endpackage

// File: rtl/rr_arb2.sv
// Combinational two-way round-robin pick; on a tie the master that was not
// served last wins.
module rr_arb2
   import soc_bus_pkg::*;
(
   input  logic [1:0] req_i,
   input  logic       last_grant_i,
   output logic       any_c,
   output logic       pick_c
);

   always_comb begin
      any_c  = |req_i;
      pick_c = MST_CPU;
      case (req_i)
         2'b01:   pick_c = MST_CPU;
         2'b10:   pick_c = MST_LDR;
         2'b11:   pick_c = ~last_grant_i;
         default: pick_c = MST_CPU;
      endcase
   end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Two-master arbiter sharing one single-port synchronous RAM between the CPU
// (master 0) and the loader/debug port (master 1), with a sticky range error.
module mem_bus_arbiter
   import soc_bus_pkg::*;
#(
   parameter int unsigned RAM_AW      = 10,
   parameter int unsigned RAM_LATENCY = 1,
   parameter logic [31:0] ERR_RDATA   = 32'h0000_0000
) (
   input  logic              clk,
   input  logic              resetn,

   input  logic              m0_valid,
   input  logic              m0_instr,
   input  logic [31:0]       m0_addr,
   input  logic [31:0]       m0_wdata,
   input  logic [3:0]        m0_wstrb,
   output logic              m0_ready,
   output logic [31:0]       m0_rdata,

   input  logic              m1_valid,
   input  logic [31:0]       m1_addr,
   input  logic [31:0]       m1_wdata,
   input  logic [3:0]        m1_wstrb,
   output logic              m1_ready,
   output logic [31:0]       m1_rdata,

   output logic              ram_en,
   output logic [3:0]        ram_we,
   output logic [RAM_AW-1:0] ram_addr,
   output logic [31:0]       ram_wdata,
   input  logic [31:0]       ram_rdata,

   output logic              grant_id,
   output logic              bus_err
);

   localparam int unsigned      CNT_W    = (RAM_LATENCY > 1) ? $clog2(RAM_LATENCY + 1) : 1;
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(RAM_LATENCY - 1);

   bus_state_e          state_q;
   logic                last_grant_q;
   logic [STRB_W-1:0]   wstrb_q;
   logic [CNT_W-1:0]    cnt_q;

   logic                req_any_c;
   logic                pick_c;
   logic                in_range_c;
   bus_req_t            sel_req_c;
   logic [DATA_W-1:0]   oor_data_c;
   logic [DATA_W-1:0]   ram_data_c;

   // The fetch qualifier carries no meaning for the access itself.
   logic                unused_instr;
   assign unused_instr = m0_instr;

   rr_arb2 u_rr_arb2 (
      .req_i        ({m1_valid, m0_valid}),
      .last_grant_i (last_grant_q),
      .any_c        (req_any_c),
      .pick_c       (pick_c)
   );

   // Payload of the master that would win arbitration this cycle.
   always_comb begin
      sel_req_c.addr  = m0_addr;
      sel_req_c.wdata = m0_wdata;
      sel_req_c.wstrb = m0_wstrb;
      if (pick_c == MST_LDR) begin
         sel_req_c.addr  = m1_addr;
         sel_req_c.wdata = m1_wdata;
         sel_req_c.wstrb = m1_wstrb;
      end
      in_range_c = addr_in_range(sel_req_c.addr, RAM_AW);
      oor_data_c = (sel_req_c.wstrb == '0) ? ERR_RDATA : '0;
      ram_data_c = (wstrb_q == '0) ? ram_rdata : '0;
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q      <= ST_IDLE;
         last_grant_q <= MST_LDR;
         grant_id     <= MST_LDR;
         wstrb_q      <= '0;
         cnt_q        <= '0;
         m0_ready     <= 1'b0;
         m0_rdata     <= '0;
         m1_ready     <= 1'b0;
         m1_rdata     <= '0;
         ram_en       <= 1'b0;
         ram_we       <= '0;
         ram_addr     <= '0;
         ram_wdata    <= '0;
         bus_err      <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (req_any_c) begin
                  grant_id <= pick_c;
                  wstrb_q  <= sel_req_c.wstrb;
                  if (in_range_c) begin
                     state_q   <= ST_ACCESS;
                     ram_en    <= 1'b1;
                     ram_we    <= sel_req_c.wstrb;
                     ram_addr  <= sel_req_c.addr[RAM_AW+1:2];
                     ram_wdata <= sel_req_c.wdata;
                  end else begin
                     // No RAM cycle: answer straight away and flag the error.
                     state_q <= ST_RESP;
                     bus_err <= 1'b1;
                     if (pick_c == MST_LDR) begin
                        m1_ready <= 1'b1;
                        m1_rdata <= oor_data_c;
                     end else begin
                        m0_ready <= 1'b1;
                        m0_rdata <= oor_data_c;
                     end
                  end
               end
            end

            ST_ACCESS: begin
               ram_en  <= 1'b0;
               ram_we  <= '0;
               cnt_q   <= CNT_LOAD;
               state_q <= ST_WAIT;
            end

            ST_WAIT: begin
               if (cnt_q == '0) begin
                  state_q <= ST_RESP;
                  if (grant_id == MST_LDR) begin
                     m1_ready <= 1'b1;
                     m1_rdata <= ram_data_c;
                  end else begin
                     m0_ready <= 1'b1;
                     m0_rdata <= ram_data_c;
                  end
               end else begin
                  cnt_q <= cnt_q - CNT_W'(1);
               end
            end

            ST_RESP: begin
               m0_ready     <= 1'b0;
               m0_rdata     <= '0;
               m1_ready     <= 1'b0;
               m1_rdata     <= '0;
               last_grant_q <= grant_id;
               state_q      <= ST_IDLE;
            end

            default: state_q <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench for mem_bus_arbiter: cycle-by-cycle vector table on the
// default-latency instance plus latency-3 and mid-transaction reset sequences.
module tb_mem_bus_arbiter;

   typedef struct packed {
      logic        v;
      logic [31:0] a;
      logic [31:0] d;
      logic [3:0]  s;
   } req_t;

   typedef struct packed {
      logic        r0;
      logic        r1;
      logic [31:0] rd0;
      logic [31:0] rd1;
      logic        en;
      logic [3:0]  we;
      logic [9:0]  ra;
      logic [31:0] wd;
      logic        g;
      logic        be;
   } obs_t;

   typedef struct {
      req_t q0;
      req_t q1;
      obs_t e;
   } vec_t;

   localparam req_t NONE    = '{1'b0, 32'h0,          32'h0,          4'h0};
   localparam req_t M0_R10  = '{1'b1, 32'h0000_0010,  32'h0,          4'h0};
   localparam req_t M0_R8   = '{1'b1, 32'h0000_0008,  32'h0,          4'h0};
   localparam req_t M0_OOR  = '{1'b1, 32'h0001_0000,  32'h0,          4'h0};
   localparam req_t M1_R14  = '{1'b1, 32'h0000_0014,  32'h0,          4'h0};
   localparam req_t M1_W8   = '{1'b1, 32'h0000_0008,  32'h1122_3344,  4'b0011};
   localparam req_t M1_OOR  = '{1'b1, 32'h8000_0000,  32'h0000_0055,  4'hF};

   localparam logic [31:0] BEEF = 32'hDEAD_BEEF;
   localparam logic [31:0] F00D = 32'hCAFE_F00D;
   localparam logic [31:0] WD1  = 32'h1122_3344;
   localparam logic [31:0] W2   = 32'hAAAA_3344;
   localparam logic [31:0] ERR  = 32'hDEAD_0BAD;

   logic clk = 1'b0;
   always #5 clk = ~clk;
   logic resetn;

   // Default-latency instance
   logic        m0_valid, m0_instr, m0_ready, m1_valid, m1_ready;
   logic [31:0] m0_addr, m0_wdata, m0_rdata, m1_addr, m1_wdata, m1_rdata;
   logic [3:0]  m0_wstrb, m1_wstrb, ram_we;
   logic        ram_en, grant_id, bus_err;
   logic [9:0]  ram_addr;
   logic [31:0] ram_wdata, ram_rdata;

   // Latency-3 instance
   logic        d3_m0_valid, d3_m0_ready, d3_m1_ready;
   logic [31:0] d3_m0_addr, d3_m0_rdata, d3_m1_rdata;
   logic [3:0]  d3_ram_we;
   logic        d3_ram_en, d3_grant_id, d3_bus_err;
   logic [9:0]  d3_ram_addr;
   logic [31:0] d3_ram_wdata, d3_ram_rdata;

   mem_bus_arbiter #(.RAM_AW(10), .RAM_LATENCY(1), .ERR_RDATA(ERR)) u_dut (
      .clk(clk), .resetn(resetn),
      .m0_valid(m0_valid), .m0_instr(m0_instr), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
      .m0_wstrb(m0_wstrb), .m0_ready(m0_ready), .m0_rdata(m0_rdata),
      .m1_valid(m1_valid), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb),
      .m1_ready(m1_ready), .m1_rdata(m1_rdata),
      .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
      .ram_rdata(ram_rdata), .grant_id(grant_id), .bus_err(bus_err)
   );

   mem_bus_arbiter #(.RAM_AW(10), .RAM_LATENCY(3), .ERR_RDATA(32'h0)) u_dut3 (
      .clk(clk), .resetn(resetn),
      .m0_valid(d3_m0_valid), .m0_instr(1'b1), .m0_addr(d3_m0_addr), .m0_wdata(32'h0),
      .m0_wstrb(4'h0), .m0_ready(d3_m0_ready), .m0_rdata(d3_m0_rdata),
      .m1_valid(1'b0), .m1_addr(32'h0), .m1_wdata(32'h0), .m1_wstrb(4'h0),
      .m1_ready(d3_m1_ready), .m1_rdata(d3_m1_rdata),
      .ram_en(d3_ram_en), .ram_we(d3_ram_we), .ram_addr(d3_ram_addr), .ram_wdata(d3_ram_wdata),
      .ram_rdata(d3_ram_rdata), .grant_id(d3_grant_id), .bus_err(d3_bus_err)
   );

   // RAM models; contents preloaded while reset is held.
   logic [31:0] mem  [0:1023];
   logic [31:0] mem3 [0:1023];
   logic [31:0] rd3_1, rd3_2;

   always @(posedge clk) begin
      if (!resetn) begin
         mem[2] <= 32'hAAAA_AAAA;
         mem[4] <= BEEF;
         mem[5] <= F00D;
      end else if (ram_en) begin
         for (int b = 0; b < 4; b++)
            if (ram_we[b]) mem[ram_addr][8*b +: 8] <= ram_wdata[8*b +: 8];
         ram_rdata <= mem[ram_addr];
      end
   end

   always @(posedge clk) begin
      if (!resetn) begin
         mem3[7] <= 32'h0BAD_CAFE;
      end else if (d3_ram_en) begin
         for (int b = 0; b < 4; b++)
            if (d3_ram_we[b]) mem3[d3_ram_addr][8*b +: 8] <= d3_ram_wdata[8*b +: 8];
         rd3_1 <= mem3[d3_ram_addr];
      end
      rd3_2        <= rd3_1;
      d3_ram_rdata <= rd3_2;
   end

   int   n_cmp;
   int   n_fail;
   vec_t vq[$];

   function automatic obs_t ob(input logic r0, input logic r1, input logic [31:0] rd0,
                               input logic [31:0] rd1, input logic en, input logic [3:0] we,
                               input logic [9:0] ra, input logic [31:0] wd, input logic g,
                               input logic be);
      obs_t o;
      o.r0 = r0; o.r1 = r1; o.rd0 = rd0; o.rd1 = rd1; o.en = en;
      o.we = we; o.ra = ra; o.wd = wd; o.g = g; o.be = be;
      return o;
   endfunction

   task automatic add(input req_t a, input req_t b, input obs_t e);
      vec_t v;
      v.q0 = a; v.q1 = b; v.e = e;
      vq.push_back(v);
   endtask

   task automatic drive(input req_t a, input req_t b);
      m0_valid = a.v; m0_addr = a.a; m0_wdata = a.d; m0_wstrb = a.s;
      m1_valid = b.v; m1_addr = b.a; m1_wdata = b.d; m1_wstrb = b.s;
   endtask

   task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, got, exp);
      end
   endtask

   function automatic obs_t sample();
      return {m0_ready, m1_ready, m0_rdata, m1_rdata, ram_en, ram_we, ram_addr,
              ram_wdata, grant_id, bus_err};
   endfunction

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int   lat;
      int   p0;
      int   p1;
      logic [31:0] rd;

      n_cmp = 0;
      n_fail = 0;
      resetn = 1'b0;
      m0_instr = 1'b0;
      drive(NONE, NONE);
      d3_m0_valid = 1'b0;
      d3_m0_addr  = 32'h0;

      // Both masters held: M0, M1, M0, M1 alternation.
      add(M0_R10, M1_R14, ob('0,'0,'0,'0,'0,'0,10'd0,'0,'1,'0));
      add(M0_R10, M1_R14, ob('0,'0,'0,'0,'1,'0,10'd4,'0,'0,'0));
      add(M0_R10, M1_R14, ob('0,'0,'0,'0,'0,'0,10'd4,'0,'0,'0));
      add(M0_R10, M1_R14, ob('1,'0,BEEF,'0,'0,'0,10'd4,'0,'0,'0));
      add(M0_R10, M1_R14, ob('0,'0,'0,'0,'0,'0,10'd4,'0,'0,'0));
      add(M0_R10, M1_R14, ob('0,'0,'0,'0,'1,'0,10'd5,'0,'1,'0));
      add(M0_R10, M1_R14, ob('0,'0,'0,'0,'0,'0,10'd5,'0,'1,'0));
      add(M0_R10, M1_R14, ob('0,'1,'0,F00D,'0,'0,10'd5,'0,'1,'0));
      add(M0_R10, M1_R14, ob('0,'0,'0,'0,'0,'0,10'd5,'0,'1,'0));
      add(M0_R10, M1_R14, ob('0,'0,'0,'0,'1,'0,10'd4,'0,'0,'0));
      add(M0_R10, M1_R14, ob('0,'0,'0,'0,'0,'0,10'd4,'0,'0,'0));
      add(M0_R10, M1_R14, ob('1,'0,BEEF,'0,'0,'0,10'd4,'0,'0,'0));
      add(M0_R10, M1_R14, ob('0,'0,'0,'0,'0,'0,10'd4,'0,'0,'0));
      add(M0_R10, M1_R14, ob('0,'0,'0,'0,'1,'0,10'd5,'0,'1,'0));
      add(M0_R10, M1_R14, ob('0,'0,'0,'0,'0,'0,10'd5,'0,'1,'0));
      add(M0_R10, M1_R14, ob('0,'1,'0,F00D,'0,'0,10'd5,'0,'1,'0));
      // Loader partial write, then CPU reads the merged word back.
      add(NONE,   M1_W8,  ob('0,'0,'0,'0,'0,'0,10'd5,'0,'1,'0));
      add(NONE,   M1_W8,  ob('0,'0,'0,'0,'1,4'b0011,10'd2,WD1,'1,'0));
      add(NONE,   M1_W8,  ob('0,'0,'0,'0,'0,'0,10'd2,WD1,'1,'0));
      add(NONE,   M1_W8,  ob('0,'1,'0,'0,'0,'0,10'd2,WD1,'1,'0));
      add(M0_R8,  NONE,   ob('0,'0,'0,'0,'0,'0,10'd2,WD1,'1,'0));
      add(M0_R8,  NONE,   ob('0,'0,'0,'0,'1,'0,10'd2,'0,'0,'0));
      add(M0_R8,  NONE,   ob('0,'0,'0,'0,'0,'0,10'd2,'0,'0,'0));
      add(M0_R8,  NONE,   ob('1,'0,W2,'0,'0,'0,10'd2,'0,'0,'0));
      // Out-of-range read and write, then a good read with bus_err sticky.
      add(M0_OOR, NONE,   ob('0,'0,'0,'0,'0,'0,10'd2,'0,'0,'0));
      add(M0_OOR, NONE,   ob('1,'0,ERR,'0,'0,'0,10'd2,'0,'0,'1));
      add(NONE,   M1_OOR, ob('0,'0,'0,'0,'0,'0,10'd2,'0,'0,'1));
      add(NONE,   M1_OOR, ob('0,'1,'0,'0,'0,'0,10'd2,'0,'1,'1));
      add(M0_R10, NONE,   ob('0,'0,'0,'0,'0,'0,10'd2,'0,'1,'1));
      add(M0_R10, NONE,   ob('0,'0,'0,'0,'1,'0,10'd4,'0,'0,'1));
      add(M0_R10, NONE,   ob('0,'0,'0,'0,'0,'0,10'd4,'0,'0,'1));
      add(M0_R10, NONE,   ob('1,'0,BEEF,'0,'0,'0,10'd4,'0,'0,'1));
      add(NONE,   NONE,   ob('0,'0,'0,'0,'0,'0,10'd4,'0,'0,'1));

      repeat (2) @(posedge clk);
      #1 resetn = 1'b1;

      for (int k = 0; k < vq.size(); k++) begin
         drive(vq[k].q0, vq[k].q1);
         m0_instr = k[0];
         @(negedge clk);
         chk($sformatf("vec%0d", k), 128'(sample()), 128'(vq[k].e));
         @(posedge clk);
         #1;
      end

      // Latency-3 instance: ready exactly 5 cycles after valid.
      d3_m0_valid = 1'b1;
      d3_m0_addr  = 32'h0000_001C;
      lat = -1;
      rd  = '0;
      for (int n = 0; n < 16; n++) begin
         @(negedge clk);
         if (d3_m0_ready) begin
            lat = n;
            rd  = d3_m0_rdata;
            chk("lat3_other_outputs", 128'({d3_m1_ready, d3_m1_rdata, d3_grant_id, d3_bus_err}),
                128'({1'b0, 32'h0, 1'b0, 1'b0}));
            break;
         end
      end
      d3_m0_valid = 1'b0;
      chk("lat3_latency", 128'(lat), 128'(5));
      chk("lat3_rdata", 128'(rd), 128'(32'h0BAD_CAFE));
      @(negedge clk);
      chk("lat3_ready_one_cycle", 128'(d3_m0_ready), 128'(1'b0));
      @(posedge clk);
      #1;

      // Reset during WAIT, then a pending loader read completes once.
      drive(M0_R10, NONE);
      repeat (2) begin
         @(posedge clk);
         #1;
      end
      drive(NONE, M1_R14);
      resetn = 1'b0;
      #1;
      chk("reset_mid_wait", 128'(sample()), 128'(ob('0,'0,'0,'0,'0,'0,10'd0,'0,'1,'0)));
      @(negedge clk);
      resetn = 1'b1;
      p0 = 0;
      p1 = 0;
      rd = '0;
      for (int n = 0; n < 12; n++) begin
         @(negedge clk);
         if (m0_ready) p0++;
         if (m1_ready) begin
            p1++;
            rd = m1_rdata;
            m1_valid = 1'b0;
         end
      end
      chk("post_reset_m1_pulses", 128'(p1), 128'(1));
      chk("post_reset_m0_pulses", 128'(p0), 128'(0));
      chk("post_reset_m1_rdata", 128'(rd), 128'(F00D));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
